// File: rtl/can_pkg.sv
// -----------------------------------------------------------------------------
// can_pkg
// Shared CAN definitions for the error handling blocks.
//   ef_state_e        : states of the error frame generator.
//   CAN_ERR_FLAG_LEN  : error flag length in bits (default parameter value).
//   CAN_ERR_DELIM_LEN : error delimiter length in recessive bits.
//   max_int()         : helper used to size counters from the parameters.
// -----------------------------------------------------------------------------
package can_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FLAG_ACT,
      FLAG_PAS,
      WAIT_REC,
      DELIM
   } ef_state_e;

   localparam int CAN_ERR_FLAG_LEN  = 6;
   localparam int CAN_ERR_DELIM_LEN = 8;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/can_error_frame_gen.sv
// -----------------------------------------------------------------------------
// can_error_frame_gen
// Turns a detected CAN error into an on-bus error frame: active or passive
// error flag, tolerance of flag superposition from other nodes, and the
// recessive error delimiter. Also reports the dominant-bit events after the
// own flag that feed the TEC/REC +8 rules.
//
// Ports:
//   clk            in  system clock
//   rst            in  asynchronous, active-low reset
//   sample_point   in  one-cycle bit sample strobe
//   rx_bit         in  sampled bus level (valid with sample_point)
//   error_detected in  any detected error, qualified by sample_point
//   error_passive  in  node is error passive (latched at flag start)
//   bus_off        in  node is bus-off; forces IDLE
//   tx_bit         out bit to drive while ef_active is high
//   ef_active      out error frame in progress
//   ef_done        out 1-cycle pulse when the delimiter completes
//   flag_bit_error out 1-cycle pulse, recessive read during an active flag bit
//   dom_after_flag out 1-cycle pulse, first dominant bit after the own flag
//   dom_seq8       out 1-cycle pulse per run of 8 dominant bits after the flag
// All outputs are registered.
// -----------------------------------------------------------------------------
module can_error_frame_gen
   import can_pkg::*;
#(
   parameter int FLAG_LEN  = CAN_ERR_FLAG_LEN,
   parameter int DELIM_LEN = CAN_ERR_DELIM_LEN
) (
   input  logic clk,
   input  logic rst,
   input  logic sample_point,
   input  logic rx_bit,
   input  logic error_detected,
   input  logic error_passive,
   input  logic bus_off,
   output logic tx_bit,
   output logic ef_active,
   output logic ef_done,
   output logic flag_bit_error,
   output logic dom_after_flag,
   output logic dom_seq8
);

   localparam int            CW          = $clog2(max_int(FLAG_LEN, DELIM_LEN) + 1);
   localparam logic [CW-1:0] FLAG_LEN_C  = CW'(FLAG_LEN);
   localparam logic [CW-1:0] DELIM_LEN_C = CW'(DELIM_LEN);
   localparam logic [CW-1:0] CNT_ONE     = CW'(1);

   ef_state_e     state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [CW-1:0] eq_cnt_reg, eq_cnt_next;
   logic          last_rx_reg, last_rx_next;
   logic [2:0]    dom_cnt_reg, dom_cnt_next;
   logic          dom_seen_reg, dom_seen_next;

   logic          ef_done_next;
   logic          flag_bit_error_next;
   logic          dom_after_flag_next;
   logic          dom_seq8_next;

   logic [CW-1:0] cnt_inc;
   logic [CW-1:0] eq_step;

   // Counters hold at all-ones instead of wrapping.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == {CW{1'b1}}) ? v : v + CNT_ONE;
   endfunction

   assign cnt_inc = sat_inc(cnt_reg);

   // Passive flag: length of the current run of equal bus levels. An empty
   // run (eq_cnt == 0) means this is the first sample of the flag.
   assign eq_step = ((eq_cnt_reg == '0) || (rx_bit != last_rx_reg)) ? CNT_ONE
                                                                     : sat_inc(eq_cnt_reg);

   // -------------------------------------------------------------------------
   // Next-state and next-output logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_next          = state_reg;
      cnt_next            = cnt_reg;
      eq_cnt_next         = eq_cnt_reg;
      last_rx_next        = last_rx_reg;
      dom_cnt_next        = dom_cnt_reg;
      dom_seen_next       = 1'b0;
      ef_done_next        = 1'b0;
      flag_bit_error_next = 1'b0;
      dom_after_flag_next = 1'b0;
      dom_seq8_next       = 1'b0;

      if (bus_off) begin
         // Bus-off overrides everything, regardless of sample_point.
         state_next   = IDLE;
         cnt_next     = '0;
         eq_cnt_next  = '0;
         last_rx_next = 1'b1;
         dom_cnt_next = '0;
      end else begin
         unique case (state_reg)
            IDLE: begin
               cnt_next     = '0;
               eq_cnt_next  = '0;
               last_rx_next = 1'b1;
               dom_cnt_next = '0;
               if (sample_point && error_detected) begin
                  state_next = error_passive ? FLAG_PAS : FLAG_ACT;
               end
            end

            FLAG_ACT: begin
               if (sample_point) begin
                  cnt_next            = cnt_inc;
                  flag_bit_error_next = rx_bit;
                  if (cnt_inc == FLAG_LEN_C) begin
                     state_next = WAIT_REC;
                  end
               end
            end

            FLAG_PAS: begin
               if (sample_point) begin
                  eq_cnt_next  = eq_step;
                  last_rx_next = rx_bit;
                  if (eq_step == FLAG_LEN_C) begin
                     state_next = WAIT_REC;
                  end
               end
            end

            WAIT_REC: begin
               dom_seen_next = dom_seen_reg;
               if (sample_point) begin
                  if (rx_bit) begin
                     // First recessive bit already counts as delimiter bit 1.
                     cnt_next = CNT_ONE;
                     if (CNT_ONE == DELIM_LEN_C) begin
                        state_next   = IDLE;
                        ef_done_next = 1'b1;
                     end else begin
                        state_next = DELIM;
                     end
                  end else begin
                     dom_seen_next       = 1'b1;
                     dom_after_flag_next = !dom_seen_reg;
                     // 3-bit wrap 7->0 marks each complete run of 8.
                     dom_cnt_next        = dom_cnt_reg + 3'd1;
                     dom_seq8_next       = (dom_cnt_reg == 3'd7);
                  end
               end
            end

            DELIM: begin
               if (sample_point) begin
                  if (rx_bit) begin
                     cnt_next = cnt_inc;
                     if (cnt_inc == DELIM_LEN_C) begin
                        state_next   = IDLE;
                        ef_done_next = 1'b1;
                     end
                  end else begin
                     // Dominant in the delimiter is a form error: new flag
                     // with the node's present error state.
                     state_next   = error_passive ? FLAG_PAS : FLAG_ACT;
                     cnt_next     = '0;
                     eq_cnt_next  = '0;
                     last_rx_next = 1'b1;
                     dom_cnt_next = '0;
                  end
               end
            end

            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // State and output registers. tx_bit/ef_active are derived from the next
   // state so the first flag bit is on the line for the whole next bit time.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         eq_cnt_reg     <= '0;
         last_rx_reg    <= 1'b1;
         dom_cnt_reg    <= '0;
         dom_seen_reg   <= 1'b0;
         tx_bit         <= 1'b1;
         ef_active      <= 1'b0;
         ef_done        <= 1'b0;
         flag_bit_error <= 1'b0;
         dom_after_flag <= 1'b0;
         dom_seq8       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         eq_cnt_reg     <= eq_cnt_next;
         last_rx_reg    <= last_rx_next;
         dom_cnt_reg    <= dom_cnt_next;
         dom_seen_reg   <= dom_seen_next;
         tx_bit         <= (state_next != FLAG_ACT);
         ef_active      <= (state_next != IDLE);
         ef_done        <= ef_done_next;
         flag_bit_error <= flag_bit_error_next;
         dom_after_flag <= dom_after_flag_next;
         dom_seq8       <= dom_seq8_next;
      end
   end

endmodule

// File: tb/tb_can_error_frame_gen.sv
// -----------------------------------------------------------------------------
// tb_can_error_frame_gen
// Directed bench for can_error_frame_gen. One sample_point every two clocks;
// outputs are checked on the falling edge right after each sample.
// -----------------------------------------------------------------------------
module tb_can_error_frame_gen;

   logic clk            = 1'b0;
   logic rst            = 1'b0;
   logic sample_point   = 1'b0;
   logic rx_bit         = 1'b1;
   logic error_detected = 1'b0;
   logic error_passive  = 1'b0;
   logic bus_off        = 1'b0;
   logic tx_bit, ef_active, ef_done, flag_bit_error, dom_after_flag, dom_seq8;

   int total = 0;
   int bad   = 0;
   int nsamp = 0;

   // Pulse counters, sampled on the rising edge (pre-update value).
   int n_done = 0, n_fbe = 0, n_daf = 0, n_seq8 = 0;
   int b_done, b_fbe, b_daf, b_seq8;

   always #5 clk = ~clk;

   can_error_frame_gen dut (
      .clk            (clk),
      .rst            (rst),
      .sample_point   (sample_point),
      .rx_bit         (rx_bit),
      .error_detected (error_detected),
      .error_passive  (error_passive),
      .bus_off        (bus_off),
      .tx_bit         (tx_bit),
      .ef_active      (ef_active),
      .ef_done        (ef_done),
      .flag_bit_error (flag_bit_error),
      .dom_after_flag (dom_after_flag),
      .dom_seq8       (dom_seq8)
   );

   always @(posedge clk) begin
      if (ef_done === 1'b1)        n_done <= n_done + 1;
      if (flag_bit_error === 1'b1) n_fbe  <= n_fbe + 1;
      if (dom_after_flag === 1'b1) n_daf  <= n_daf + 1;
      if (dom_seq8 === 1'b1)       n_seq8 <= n_seq8 + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One bit time: strobe sample_point for one cycle, return on the
   // following falling edge where the registered results are visible.
   task automatic samp(input logic rx);
      @(negedge clk);
      sample_point = 1'b1;
      rx_bit       = rx;
      @(negedge clk);
      sample_point = 1'b0;
      nsamp++;
      $display("sample %0d rx=%0b err=%0b ep=%0b boff=%0b -> tx=%0b act=%0b done=%0b fbe=%0b daf=%0b seq8=%0b",
               nsamp, rx, error_detected, error_passive, bus_off, tx_bit, ef_active,
               ef_done, flag_bit_error, dom_after_flag, dom_seq8);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic mark();
      b_done = n_done;
      b_fbe  = n_fbe;
      b_daf  = n_daf;
      b_seq8 = n_seq8;
   endtask

   // Start an error frame from IDLE.
   task automatic trigger(input logic passive);
      error_passive  = passive;
      error_detected = 1'b1;
      samp(1'b1);
      error_detected = 1'b0;
   endtask

   initial begin
      // ---------------- reset values ----------------
      idle(3);
      chk("rst_tx", tx_bit, 1'b1);
      chk("rst_act", ef_active, 1'b0);
      chk("rst_done", ef_done, 1'b0);
      chk("rst_pulses", {flag_bit_error, dom_after_flag, dom_seq8}, 3'b000);
      rst = 1'b1;
      idle(2);

      // ---------------- 1: active flag, bus echoes, clean delimiter --------
      mark();
      trigger(1'b0);
      chk("t1_start_tx", tx_bit, 1'b0);
      chk("t1_start_act", ef_active, 1'b1);
      for (int i = 1; i <= 6; i++) begin
         samp(1'b0);
         chk("t1_flag_tx", tx_bit, (i == 6));
         chk("t1_flag_act", ef_active, 1'b1);
      end
      for (int i = 1; i <= 8; i++) begin
         samp(1'b1);
         chk("t1_delim_done", ef_done, (i == 8));
         chk("t1_delim_act", ef_active, (i != 8));
      end
      idle(2);
      chk("t1_done_cnt", n_done - b_done, 1);
      chk("t1_daf_cnt", n_daf - b_daf, 0);
      chk("t1_seq8_cnt", n_seq8 - b_seq8, 0);
      chk("t1_fbe_cnt", n_fbe - b_fbe, 0);

      // ---------------- 2: three superposition bits ------------------------
      mark();
      trigger(1'b0);
      for (int i = 1; i <= 6; i++) samp(1'b0);
      for (int i = 1; i <= 3; i++) begin
         samp(1'b0);
         chk("t2_daf", dom_after_flag, (i == 1));
         chk("t2_seq8", dom_seq8, 1'b0);
      end
      for (int i = 1; i <= 8; i++) begin
         samp(1'b1);
         chk("t2_done", ef_done, (i == 8));
      end
      idle(2);
      chk("t2_done_cnt", n_done - b_done, 1);
      chk("t2_daf_cnt", n_daf - b_daf, 1);
      chk("t2_seq8_cnt", n_seq8 - b_seq8, 0);

      // ---------------- 3: passive flag, pattern 1,0,0,0,0,0,0 -------------
      mark();
      trigger(1'b1);
      chk("t3_start_act", ef_active, 1'b1);
      chk("t3_start_tx", tx_bit, 1'b1);
      error_passive = 1'b0;
      for (int i = 0; i < 7; i++) begin
         samp(i == 0);
         chk("t3_flag_tx", tx_bit, 1'b1);
         chk("t3_flag_daf", dom_after_flag, 1'b0);
         chk("t3_flag_fbe", flag_bit_error, 1'b0);
      end
      for (int i = 1; i <= 8; i++) begin
         samp(1'b1);
         chk("t3_done", ef_done, (i == 8));
         chk("t3_tx", tx_bit, 1'b1);
      end
      idle(2);
      chk("t3_done_cnt", n_done - b_done, 1);
      chk("t3_daf_cnt", n_daf - b_daf, 0);

      // ---------------- 4: 17 dominant bits after the flag -----------------
      mark();
      trigger(1'b0);
      for (int i = 1; i <= 6; i++) samp(1'b0);
      for (int i = 1; i <= 17; i++) begin
         samp(1'b0);
         chk("t4_daf", dom_after_flag, (i == 1));
         chk("t4_seq8", dom_seq8, (i == 8 || i == 16));
         chk("t4_act", ef_active, 1'b1);
      end
      for (int i = 1; i <= 8; i++) begin
         samp(1'b1);
         chk("t4_done", ef_done, (i == 8));
      end
      idle(2);
      chk("t4_daf_cnt", n_daf - b_daf, 1);
      chk("t4_seq8_cnt", n_seq8 - b_seq8, 2);
      chk("t4_done_cnt", n_done - b_done, 1);

      // ---------------- 5: dominant on delimiter bit 4 ---------------------
      mark();
      trigger(1'b0);
      for (int i = 1; i <= 6; i++) samp(1'b0);
      for (int i = 1; i <= 3; i++) begin
         samp(1'b1);
         chk("t5_delim_tx", tx_bit, 1'b1);
      end
      samp(1'b0);
      chk("t5_restart_tx", tx_bit, 1'b0);
      chk("t5_restart_act", ef_active, 1'b1);
      chk("t5_restart_done", ef_done, 1'b0);
      for (int i = 1; i <= 6; i++) begin
         samp(i == 2);
         chk("t5_flag_fbe", flag_bit_error, (i == 2));
         chk("t5_flag_tx", tx_bit, (i == 6));
      end
      for (int i = 1; i <= 8; i++) begin
         samp(1'b1);
         chk("t5_done", ef_done, (i == 8));
      end
      idle(2);
      chk("t5_done_cnt", n_done - b_done, 1);
      chk("t5_fbe_cnt", n_fbe - b_fbe, 1);

      // ---------------- 6: bus_off during active flag bit 3 ----------------
      mark();
      trigger(1'b0);
      samp(1'b0);
      samp(1'b0);
      chk("t6_pre_tx", tx_bit, 1'b0);
      bus_off = 1'b1;
      @(negedge clk);
      chk("t6_boff_tx", tx_bit, 1'b1);
      chk("t6_boff_act", ef_active, 1'b0);
      error_detected = 1'b1;
      samp(1'b0);
      error_detected = 1'b0;
      chk("t6_boff_err_ignored", ef_active, 1'b0);
      bus_off = 1'b0;
      samp(1'b0);
      chk("t6_after_act", ef_active, 1'b0);
      idle(2);
      chk("t6_done_cnt", n_done - b_done, 0);

      // ---------------- 7: asynchronous reset mid-delimiter ----------------
      mark();
      trigger(1'b0);
      for (int i = 1; i <= 6; i++) samp(1'b0);
      for (int i = 1; i <= 3; i++) samp(1'b1);
      chk("t7_pre_act", ef_active, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      chk("t7_rst_act", ef_active, 1'b0);
      chk("t7_rst_tx", tx_bit, 1'b1);
      chk("t7_rst_pulses", {ef_done, flag_bit_error, dom_after_flag, dom_seq8}, 4'b0000);
      @(negedge clk);
      rst = 1'b1;
      idle(2);
      chk("t7_done_cnt", n_done - b_done, 0);
      trigger(1'b0);
      chk("t7_recover_tx", tx_bit, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
